// File: rtl/nn_ops_pkg.sv
// Shared types and constant helpers for the nn_ops datapath blocks (prod_acc, sat_add).
package nn_ops_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } prod_acc_state_t;

  localparam int MAX_W = 128;

  // Two's-complement extremes for a w-bit word, returned zero-extended to MAX_W bits.
  function automatic logic [MAX_W-1:0] signed_max(input int w);
    signed_max = (MAX_W'(1) << (w - 1)) - MAX_W'(1);
  endfunction

  function automatic logic [MAX_W-1:0] signed_min(input int w);
    signed_min = MAX_W'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/prod_acc_if.sv
// Handshake bundle around prod_acc: upstream term channel, clear, and downstream result channel.
interface prod_acc_if #(
  parameter int WIDTH = 64,
  parameter int LEN   = 16
);
  localparam int CW = $clog2(LEN + 1);

  logic [WIDTH-1:0] acc_i;
  logic             acc_valid_i;
  logic             acc_ready_o;
  logic             acc_clr_i;
  logic [WIDTH-1:0] acc_o;
  logic             acc_valid_o;
  logic             acc_ready_i;
  logic [CW-1:0]    acc_cnt_o;
  logic             acc_ovf_o;

  // master: the side that feeds terms and consumes results
  modport master (
    output acc_i, acc_valid_i, acc_clr_i, acc_ready_i,
    input  acc_ready_o, acc_o, acc_valid_o, acc_cnt_o, acc_ovf_o
  );

  modport slave (
    input  acc_i, acc_valid_i, acc_clr_i, acc_ready_i,
    output acc_ready_o, acc_o, acc_valid_o, acc_cnt_o, acc_ovf_o
  );

endinterface

// File: rtl/sat_add.sv
// WIDTH-bit signed adder; saturates and flags overflow when PROD_ACC_SAT_EN is defined,
// otherwise wraps modulo 2^WIDTH with ovf held at 0.
module sat_add
  import nn_ops_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  logic [WIDTH-1:0] raw;
  assign raw = a + b;

`ifdef PROD_ACC_SAT_EN
  localparam logic [WIDTH-1:0] SMAX = WIDTH'(signed_max(WIDTH));
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(signed_min(WIDTH));

  // Overflow only when both operands share a sign and the raw result flips it.
  always_comb begin
    ovf = (a[WIDTH-1] == b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
    sum = raw;
    if (ovf) sum = a[WIDTH-1] ? SMIN : SMAX;
  end
`else
  assign sum = raw;
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/prod_acc.sv
// Sums LEN signed product terms into one result and presents it on a valid/ready output.
// Optional saturation is enabled by defining PROD_ACC_SAT_EN (see sat_add).
module prod_acc
  import nn_ops_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int LEN   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           acc_i,
  input  logic                       acc_valid_i,
  output logic                       acc_ready_o,
  input  logic                       acc_clr_i,
  output logic [WIDTH-1:0]           acc_o,
  output logic                       acc_valid_o,
  input  logic                       acc_ready_i,
  output logic [$clog2(LEN+1)-1:0]   acc_cnt_o,
  output logic                       acc_ovf_o,
  output prod_acc_state_t            dbg_state
);

  localparam int            CW     = $clog2(LEN + 1);
  localparam logic [CW-1:0] LEN_C  = CW'(LEN);
  localparam bit            LEN_ONE = (LEN == 1);

  // Handshakes: a term transfers on a rising edge where acc_valid_i && acc_ready_o;
  // a result transfers where acc_valid_o && acc_ready_i. Sources hold data until transfer.

  prod_acc_state_t  state_q, state_d;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt_q;
  logic             ovf_q;
  logic             accept;
  logic [CW-1:0]    cnt_inc;
  logic [WIDTH-1:0] add_sum;
  logic             add_ovf;

  assign accept  = acc_valid_i && acc_ready_o;
  assign cnt_inc = cnt_q + CW'(1);

  sat_add #(.WIDTH(WIDTH)) u_sat_add (
    .a   (sum_q),
    .b   (acc_i),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; clear overrides every other event
  always_comb begin
    state_d = state_q;
    if (acc_clr_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = LEN_ONE ? HOLD : ACCUM;
        ACCUM:   if (accept && (cnt_inc == LEN_C)) state_d = HOLD;
        HOLD:    if (acc_ready_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    acc_ready_o = 1'b1;
    acc_valid_o = 1'b0;
    case (state_q)
      HOLD: begin
        acc_ready_o = 1'b0;
        acc_valid_o = 1'b1;
      end
      default: begin
        acc_ready_o = 1'b1;
        acc_valid_o = 1'b0;
      end
    endcase
  end

  // Datapath: running sum, term count and sticky overflow for the current result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (acc_clr_i) begin
      sum_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          sum_q <= acc_i;
          cnt_q <= CW'(1);
          ovf_q <= 1'b0;
        end
        ACCUM: if (accept) begin
          sum_q <= add_sum;
          cnt_q <= cnt_inc;
          ovf_q <= ovf_q | add_ovf;
        end
        HOLD: if (acc_ready_i) begin
          cnt_q <= '0;
          ovf_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign acc_o     = sum_q;
  assign acc_cnt_o = cnt_q;
  assign acc_ovf_o = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_prod_acc.sv
// Directed bench for prod_acc: a WIDTH=16/LEN=4 instance and a LEN=1 instance on one clock.
module tb_prod_acc;
  import nn_ops_pkg::*;

  logic clk;
  logic rst;
  int   n_total = 0;
  int   n_bad   = 0;

  prod_acc_if #(.WIDTH(16), .LEN(4)) bus_a ();
  prod_acc_if #(.WIDTH(16), .LEN(1)) bus_b ();
  prod_acc_state_t st_a, st_b;

  prod_acc #(.WIDTH(16), .LEN(4)) u_dut (
    .clk(clk), .rst(rst),
    .acc_i(bus_a.acc_i), .acc_valid_i(bus_a.acc_valid_i), .acc_ready_o(bus_a.acc_ready_o),
    .acc_clr_i(bus_a.acc_clr_i), .acc_o(bus_a.acc_o), .acc_valid_o(bus_a.acc_valid_o),
    .acc_ready_i(bus_a.acc_ready_i), .acc_cnt_o(bus_a.acc_cnt_o), .acc_ovf_o(bus_a.acc_ovf_o),
    .dbg_state(st_a)
  );

  prod_acc #(.WIDTH(16), .LEN(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .acc_i(bus_b.acc_i), .acc_valid_i(bus_b.acc_valid_i), .acc_ready_o(bus_b.acc_ready_o),
    .acc_clr_i(bus_b.acc_clr_i), .acc_o(bus_b.acc_o), .acc_valid_o(bus_b.acc_valid_o),
    .acc_ready_i(bus_b.acc_ready_i), .acc_cnt_o(bus_b.acc_cnt_o), .acc_ovf_o(bus_b.acc_ovf_o),
    .dbg_state(st_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one term to DUT A and wait (bounded) for it to be accepted.
  task automatic send(input logic [15:0] t);
    int   n;
    logic ok;
    n = 0;
    bus_a.acc_valid_i = 1'b1;
    bus_a.acc_i       = t;
    while (!bus_a.acc_ready_o && n < 20) begin
      step();
      n++;
    end
    ok = bus_a.acc_ready_o;
    step();
    bus_a.acc_valid_i = 1'b0;
    bus_a.acc_i       = 'x;
    check("send_accepted", {63'd0, ok}, 64'd1);
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_acc"},   {48'd0, bus_a.acc_o}, 64'd0);
    check({tag, "_valid"}, {63'd0, bus_a.acc_valid_o}, 64'd0);
    check({tag, "_ready"}, {63'd0, bus_a.acc_ready_o}, 64'd1);
    check({tag, "_cnt"},   {61'd0, bus_a.acc_cnt_o}, 64'd0);
    check({tag, "_ovf"},   {63'd0, bus_a.acc_ovf_o}, 64'd0);
  endtask

  initial begin
    bus_a.acc_i = '0; bus_a.acc_valid_i = 0; bus_a.acc_clr_i = 0; bus_a.acc_ready_i = 1;
    bus_b.acc_i = '0; bus_b.acc_valid_i = 0; bus_b.acc_clr_i = 0; bus_b.acc_ready_i = 1;
    rst = 1'b1;
    #3;
    check_reset_a("rst");
    check("rst_b_ready", {63'd0, bus_b.acc_ready_o}, 64'd1);
    check("rst_b_valid", {63'd0, bus_b.acc_valid_o}, 64'd0);
    step();
    rst = 1'b0;

    // idle with X on acc_i and valid low: nothing accepted
    bus_a.acc_i = 'x;
    repeat (3) step();
    check("idle_x_cnt", {61'd0, bus_a.acc_cnt_o}, 64'd0);

    // basic sum 1+2+3+4 with downstream ready
    send(16'd1); check("basic_cnt1", {61'd0, bus_a.acc_cnt_o}, 64'd1);
    send(16'd2); check("basic_cnt2", {61'd0, bus_a.acc_cnt_o}, 64'd2);
    send(16'd3); check("basic_cnt3", {61'd0, bus_a.acc_cnt_o}, 64'd3);
    check("basic_valid_early", {63'd0, bus_a.acc_valid_o}, 64'd0);
    send(16'd4);
    check("basic_valid", {63'd0, bus_a.acc_valid_o}, 64'd1);
    check("basic_acc",   {48'd0, bus_a.acc_o}, 64'd10);
    check("basic_ready", {63'd0, bus_a.acc_ready_o}, 64'd0);
    step();
    check("basic_valid_drop", {63'd0, bus_a.acc_valid_o}, 64'd0);
    check("basic_cnt_clr",    {61'd0, bus_a.acc_cnt_o}, 64'd0);

    // gap inside a result leaves the count alone, then back-pressure on HOLD
    bus_a.acc_ready_i = 1'b0;
    send(16'd1);
    repeat (2) step();
    check("gap_cnt", {61'd0, bus_a.acc_cnt_o}, 64'd1);
    send(16'd2); send(16'd3); send(16'd4);
    bus_a.acc_valid_i = 1'b1;
    bus_a.acc_i       = 16'd100;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {63'd0, bus_a.acc_valid_o}, 64'd1);
      check("bp_acc",   {48'd0, bus_a.acc_o}, 64'd10);
      check("bp_ready", {63'd0, bus_a.acc_ready_o}, 64'd0);
      check("bp_cnt",   {61'd0, bus_a.acc_cnt_o}, 64'd4);
      step();
    end
    bus_a.acc_valid_i = 1'b0;
    bus_a.acc_i       = 'x;
    bus_a.acc_ready_i = 1'b1;
    step();
    check("bp_release_valid", {63'd0, bus_a.acc_valid_o}, 64'd0);
    send(16'd5); send(16'd5); send(16'd5); send(16'hFFFB);
    check("neg_acc", {48'd0, bus_a.acc_o}, 64'd10);
    step();

    // large positive terms: saturate or wrap depending on build
    repeat (4) send(16'h7000);
    check("ovf_valid", {63'd0, bus_a.acc_valid_o}, 64'd1);
`ifdef PROD_ACC_SAT_EN
    check("ovf_acc",  {48'd0, bus_a.acc_o}, 64'h7FFF);
    check("ovf_flag", {63'd0, bus_a.acc_ovf_o}, 64'd1);
`else
    check("ovf_acc",  {48'd0, bus_a.acc_o}, 64'hC000);
    check("ovf_flag", {63'd0, bus_a.acc_ovf_o}, 64'd0);
`endif
    step();
    check("ovf_cleared", {63'd0, bus_a.acc_ovf_o}, 64'd0);

    // clear after 2 accepts, then a fresh result of four 1s
    send(16'd9); send(16'd9);
    bus_a.acc_clr_i = 1'b1;
    step();
    bus_a.acc_clr_i = 1'b0;
    check("clr_acc",   {48'd0, bus_a.acc_o}, 64'd0);
    check("clr_cnt",   {61'd0, bus_a.acc_cnt_o}, 64'd0);
    check("clr_ready", {63'd0, bus_a.acc_ready_o}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      check("clr_seq_cnt", {61'd0, bus_a.acc_cnt_o}, 64'(i));
      send(16'd1);
    end
    check("clr_res_valid", {63'd0, bus_a.acc_valid_o}, 64'd1);
    check("clr_res_acc",   {48'd0, bus_a.acc_o}, 64'd4);
    step();

    // clear while a result is held drops it
    bus_a.acc_ready_i = 1'b0;
    repeat (4) send(16'd2);
    check("hold_clr_pre", {63'd0, bus_a.acc_valid_o}, 64'd1);
    bus_a.acc_clr_i = 1'b1;
    step();
    bus_a.acc_clr_i = 1'b0;
    bus_a.acc_ready_i = 1'b1;
    check("hold_clr_valid", {63'd0, bus_a.acc_valid_o}, 64'd0);
    check("hold_clr_cnt",   {61'd0, bus_a.acc_cnt_o}, 64'd0);

    // asynchronous reset mid-result at cnt=3
    send(16'd1); send(16'd2); send(16'd3);
    check("arst_pre_cnt", {61'd0, bus_a.acc_cnt_o}, 64'd3);
    #2 rst = 1'b1;
    #1;
    check_reset_a("arst");
    step();
    #2 rst = 1'b0;
    step();
    send(16'd5); send(16'd6); send(16'd7); send(16'd8);
    check("arst_res_acc", {48'd0, bus_a.acc_o}, 64'd26);
    step();

    // LEN=1: two back-to-back results separated by one bubble
    bus_b.acc_valid_i = 1'b1;
    bus_b.acc_i       = 16'd7;
    check("len1_ready0", {63'd0, bus_b.acc_ready_o}, 64'd1);
    step();
    bus_b.acc_i = 16'd9;
    check("len1_valid7", {63'd0, bus_b.acc_valid_o}, 64'd1);
    check("len1_acc7",   {48'd0, bus_b.acc_o}, 64'd7);
    check("len1_bubble", {63'd0, bus_b.acc_ready_o}, 64'd0);
    step();
    check("len1_gap_valid", {63'd0, bus_b.acc_valid_o}, 64'd0);
    check("len1_gap_ready", {63'd0, bus_b.acc_ready_o}, 64'd1);
    step();
    bus_b.acc_valid_i = 1'b0;
    check("len1_valid9", {63'd0, bus_b.acc_valid_o}, 64'd1);
    check("len1_acc9",   {48'd0, bus_b.acc_o}, 64'd9);
    step();
    check("len1_done", {63'd0, bus_b.acc_valid_o}, 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
